// File: rtl/rate_select_counter.sv
// Up/down counter stepped by clock-enable ticks from one free-running prescaler; rate chosen by RateSel.
// Count/Tick/Carry are registered, one edge after the tick condition; no backpressure, Load has priority.
module rate_select_counter #(
   parameter int WIDTH         = 4,
   parameter int NUM_RATES     = 4,
   parameter int SEL_W         = 2,
   parameter int PRESCALE_BITS = 27,
   parameter int BASE_BIT      = 20,
   parameter int RATE_STEP     = 2
) (
   input  logic             FastClk,
   input  logic             ResetN,
   input  logic [SEL_W-1:0] RateSel,
   input  logic             Enable,
   input  logic             Dir,
   input  logic             Saturate,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   output logic [WIDTH-1:0] Count,
   output logic             Tick,
   output logic             Carry
);
   localparam logic [WIDTH-1:0] MAX = '1;

   logic [PRESCALE_BITS-1:0] prescaler;
   logic [PRESCALE_BITS-1:0] tick_mask;
   logic [SEL_W-1:0]         rate_q;
   logic [SEL_W-1:0]         rate_eff;
   logic                     rate_change;
   logic                     tick_int;
   logic [WIDTH-1:0]         count_nxt;
   logic                     carry_nxt;

   // Out-of-range selections fold onto the slowest rate.
   always_comb begin
      rate_eff = RateSel;
      if (int'(RateSel) >= NUM_RATES)
         rate_eff = SEL_W'(NUM_RATES - 1);
   end

   // Low K bits of the prescaler all ones marks the end of a 2^K period; K = 0 ticks every cycle.
   always_comb begin
      tick_mask = '0;
      for (int i = 0; i < PRESCALE_BITS; i++)
         tick_mask[i] = (i < BASE_BIT + int'(rate_q) * RATE_STEP);
   end

   assign rate_change = (rate_eff != rate_q);
   assign tick_int    = !rate_change && ((prescaler & tick_mask) == tick_mask);

   always_comb begin
      count_nxt = Count;
      carry_nxt = 1'b0;
      if (Dir) begin
         if (Count == MAX) begin
            carry_nxt = 1'b1;
            count_nxt = Saturate ? MAX : '0;
         end else begin
            count_nxt = Count + 1'b1;
         end
      end else begin
         if (Count == '0) begin
            carry_nxt = 1'b1;
            count_nxt = Saturate ? '0 : MAX;
         end else begin
            count_nxt = Count - 1'b1;
         end
      end
   end

   always_ff @(posedge FastClk) begin
      if (!ResetN) begin
         prescaler <= '0;
         rate_q    <= rate_eff;
         Count     <= '0;
         Tick      <= 1'b0;
         Carry     <= 1'b0;
      end else begin
         // A rate change restarts the period so the new rate gets a full first interval.
         prescaler <= rate_change ? '0 : prescaler + 1'b1;
         rate_q    <= rate_eff;
         Tick      <= 1'b0;
         Carry     <= 1'b0;
         if (Load) begin
            Count <= LoadValue;
         end else if (tick_int && Enable) begin
            Count <= count_nxt;
            Tick  <= 1'b1;
            Carry <= carry_nxt;
         end
      end
   end
endmodule

// File: tb/tb_rate_select_counter.sv
// Directed + random bench for rate_select_counter against a cycle-count reference model.
module tb_rate_select_counter;
   localparam int W  = 4;
   localparam int NR = 4;
   localparam int SW = 2;
   localparam int PB = 8;
   localparam int BB = 2;
   localparam int RS = 1;
   localparam int MX = (1 << W) - 1;

   logic          FastClk;
   logic          ResetN;
   logic [SW-1:0] RateSel;
   logic          Enable;
   logic          Dir;
   logic          Saturate;
   logic          Load;
   logic [W-1:0]  LoadValue;
   logic [W-1:0]  Count;
   logic          Tick;
   logic          Carry;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state: phase = cycles since the period was last restarted
   int m_count, m_phase, m_rate;
   bit m_tick, m_carry;

   rate_select_counter #(
      .WIDTH(W), .NUM_RATES(NR), .SEL_W(SW),
      .PRESCALE_BITS(PB), .BASE_BIT(BB), .RATE_STEP(RS)
   ) dut (
      .FastClk(FastClk), .ResetN(ResetN), .RateSel(RateSel), .Enable(Enable),
      .Dir(Dir), .Saturate(Saturate), .Load(Load), .LoadValue(LoadValue),
      .Count(Count), .Tick(Tick), .Carry(Carry)
   );

   initial begin
      FastClk = 1'b0;
      forever #5 FastClk = ~FastClk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge: model applies the inputs seen at the edge, then all outputs are compared.
   task automatic cyc();
      int eff, per;
      bit tk;
      logic rst_n, ld, en, dr, sat;
      logic [W-1:0] lv;
      @(posedge FastClk);
      eff   = (int'(RateSel) >= NR) ? NR - 1 : int'(RateSel);
      rst_n = ResetN; ld = Load; lv = LoadValue; en = Enable; dr = Dir; sat = Saturate;
      #1;
      if (!rst_n) begin
         m_count = 0; m_tick = 0; m_carry = 0; m_phase = 0; m_rate = eff;
      end else begin
         per = 1 << (BB + m_rate * RS);
         tk  = (eff == m_rate) && ((m_phase % per) == per - 1);
         if (eff != m_rate) begin
            m_rate  = eff;
            m_phase = 0;
         end else begin
            m_phase = (m_phase + 1) % (1 << PB);
         end
         m_tick  = 0;
         m_carry = 0;
         if (ld) begin
            m_count = int'(lv);
         end else if (tk && en) begin
            m_tick = 1;
            if (dr) begin
               if (m_count == MX) begin m_carry = 1; m_count = sat ? MX : 0; end
               else m_count = m_count + 1;
            end else begin
               if (m_count == 0) begin m_carry = 1; m_count = sat ? 0 : MX; end
               else m_count = m_count - 1;
            end
         end
      end
      chk("count", 32'(Count), 32'(m_count));
      chk("tick",  32'(Tick),  32'(m_tick));
      chk("carry", 32'(Carry), 32'(m_carry));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Clocks until Tick is seen (bounded); returns the number of edges taken.
   task automatic wait_tick(output int n);
      n = 0;
      for (int i = 0; i < 80; i++) begin
         cyc();
         n++;
         if (Tick === 1'b1) break;
      end
      chk("tick_seen", 32'(Tick), 32'd1);
   endtask

   task automatic load(input int v);
      Load = 1'b1; LoadValue = W'(v);
      cyc();
      Load = 1'b0;
   endtask

   initial begin
      int n;
      ResetN = 1'b0; RateSel = '0; Enable = 1'b1; Dir = 1'b1;
      Saturate = 1'b0; Load = 1'b0; LoadValue = '0;

      // reset and release
      run(3);
      chk("rst_count", 32'(Count), 32'd0);
      ResetN = 1'b1;
      run(3);
      chk("pre_first_step", 32'(Count), 32'd0);
      cyc();
      chk("first_step", 32'(Count), 32'd1);
      chk("first_tick", 32'(Tick), 32'd1);
      wait_tick(n);
      chk("period0", 32'(n), 32'd4);

      // up wrap, then up saturate
      load(14);
      wait_tick(n); chk("upw_15", 32'(Count), 32'd15);
      wait_tick(n); chk("upw_0", 32'(Count), 32'd0); chk("upw_carry", 32'(Carry), 32'd1);
      Saturate = 1'b1;
      load(14);
      wait_tick(n); chk("ups_15", 32'(Count), 32'd15);
      wait_tick(n); chk("ups_hold", 32'(Count), 32'd15); chk("ups_carry", 32'(Carry), 32'd1);

      // down wrap, then disabled
      Saturate = 1'b0; Dir = 1'b0;
      load(1);
      wait_tick(n); chk("dn_0", 32'(Count), 32'd0);
      wait_tick(n); chk("dn_15", 32'(Count), 32'd15); chk("dn_carry", 32'(Carry), 32'd1);
      Enable = 1'b0;
      run(20);
      chk("frozen", 32'(Count), 32'd15);

      // rate change mid-period
      Enable = 1'b1; Dir = 1'b1;
      wait_tick(n);
      cyc();
      RateSel = 2'd2;
      cyc();
      chk("no_tick_on_change", 32'(Tick), 32'd0);
      wait_tick(n); chk("first_after_change", 32'(n), 32'd16);
      wait_tick(n); chk("period2", 32'(n), 32'd16);
      RateSel = 2'd3;
      cyc();
      wait_tick(n); chk("first_rate3", 32'(n), 32'd32);
      wait_tick(n); chk("period3", 32'(n), 32'd32);

      // load colliding with a tick edge
      RateSel = 2'd0;
      cyc();
      wait_tick(n);
      run(3);
      Load = 1'b1; LoadValue = 4'd9;
      cyc();
      Load = 1'b0;
      chk("coll_count", 32'(Count), 32'd9);
      chk("coll_tick", 32'(Tick), 32'd0);
      chk("coll_carry", 32'(Carry), 32'd0);
      wait_tick(n);
      chk("coll_next", 32'(n), 32'd4);
      chk("coll_next_count", 32'(Count), 32'd10);

      // reset mid-period
      load(7);
      cyc();
      ResetN = 1'b0;
      cyc();
      chk("midrst_count", 32'(Count), 32'd0);
      chk("midrst_carry", 32'(Carry), 32'd0);
      ResetN = 1'b1;
      wait_tick(n);
      chk("midrst_period", 32'(n), 32'd4);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         ResetN    = ($urandom_range(0, 199) != 0);
         Load      = ($urandom_range(0, 29) == 0);
         LoadValue = W'($urandom);
         Enable    = ($urandom_range(0, 7) != 0);
         Dir       = 1'($urandom);
         Saturate  = 1'($urandom);
         if ($urandom_range(0, 59) == 0) RateSel = SW'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
